// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit: opcodes, ALU command
// classes, ALU flag bit positions, FSM states, datapath select codes, instruction classes.
// Latency: n/a (declarations only). Backpressure: n/a.
package riscv_pkg;

  // Base opcodes recognised by the decoder
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // ALU operation classes
  localparam logic [3:0] ALU_R     = 4'b0000;
  localparam logic [3:0] ALU_I     = 4'b0001;
  localparam logic [3:0] ALU_MEM   = 4'b0010;
  localparam logic [3:0] ALU_BR    = 4'b0011;
  localparam logic [3:0] ALU_ADDPC = 4'b0100;
  localparam logic [3:0] ALU_LUI   = 4'b0101;

  // alu_flags bit positions
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_MSB  = 1;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_ONE  = 3;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] ASEL_RS1  = 2'b00;
  localparam logic [1:0] ASEL_PC   = 2'b01;
  localparam logic [1:0] ASEL_ZERO = 2'b10;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILL
  } cls_t;

  function automatic cls_t opcode_class(input logic [6:0] opc);
    case (opc)
      OPC_R:      return CLS_R;
      OPC_I:      return CLS_I;
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_JAL:    return CLS_JAL;
      OPC_JALR:   return CLS_JALR;
      OPC_LUI:    return CLS_LUI;
      OPC_AUIPC:  return CLS_AUIPC;
      default:    return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/branch_resolver.sv
// Resolves a conditional branch from funct3 and the ALU flags (BEQ/BNE/BLT/BGE).
// Latency: combinational. Backpressure: none.
// Ports: funct3, alu_flags in; taken, unsupported (unsigned compares: no carry flag) out.
module branch_resolver
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [3:0] alu_flags,
  output logic       taken,
  output logic       unsupported
);

  logic w_lt;
  logic w_unused;

  // Signed less-than from a subtraction: sign of result corrected by overflow
  assign w_lt     = alu_flags[FLAG_MSB] ^ alu_flags[FLAG_OVF];
  assign w_unused = alu_flags[FLAG_ONE];

  always_comb begin
    taken       = 1'b0;
    unsupported = 1'b0;
    case (funct3)
      3'b000:  taken = alu_flags[FLAG_ZERO];
      3'b001:  taken = ~alu_flags[FLAG_ZERO];
      3'b100:  taken = w_lt;
      3'b101:  taken = ~w_lt;
      default: unsupported = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_control_unit.sv
// Multi-cycle control FSM: fetch/decode/execute/mem/writeback, drives ALU command and datapath selects.
// Latency: 4 cycles ALU/jump/STORE, 3 BRANCH, 5 LOAD with zero-wait memories.
// Backpressure: FETCH stalls on imem_ready, MEM stalls on dmem_ready; each stall cycle adds one cycle.
// Ports: clk/reset (sync, active-high); opcode/funct3/funct7 from IR; alu_flags from ALU;
//   imem_ready/dmem_ready handshakes; alu_cmd/alu_a_sel/alu_src, pc_src/pc_load, ir_load,
//   imem_req, dmem_req/dmem_we, rf_we/wb_sel, sticky illegal and debug state out.
module riscv_control_unit
  import riscv_pkg::*;
#(
  parameter int XLEN            = 64,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic [3:0] alu_flags,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic [3:0] alu_cmd,
  output logic [1:0] alu_a_sel,
  output logic       alu_src,
  output logic [1:0] pc_src,
  output logic       pc_load,
  output logic       ir_load,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic [2:0] state
);

  state_t     r_state;
  cls_t       r_cls;
  logic       r_illegal;

  cls_t       w_dec_cls;
  logic       w_dec_illegal;
  logic       w_taken;
  logic       w_br_unsupported;
  logic [3:0] w_alu_cmd;
  logic [1:0] w_alu_a_sel;
  logic       w_alu_src;
  logic       w_unused;

  // Class-level control does not distinguish funct7 variants; XLEN is informational
  assign w_unused = ^funct7 ^ (XLEN == 0);

  branch_resolver u_branch_resolver (
    .funct3      (funct3),
    .alu_flags   (alu_flags),
    .taken       (w_taken),
    .unsupported (w_br_unsupported)
  );

  always_comb begin
    w_dec_cls     = opcode_class(opcode);
    w_dec_illegal = (w_dec_cls == CLS_ILL) ||
                    ((w_dec_cls == CLS_BRANCH) && w_br_unsupported);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_cls     <= CLS_R;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: if (imem_ready) r_state <= ST_DECODE;
        ST_DECODE: begin
          if (w_dec_illegal) begin
            r_cls     <= CLS_ILL;
            r_illegal <= 1'b1;
            // In NOP mode the ILL class takes one EXECUTE cycle to step the PC
            r_state   <= HALT_ON_ILLEGAL ? ST_HALT : ST_EXECUTE;
          end else begin
            r_cls   <= w_dec_cls;
            r_state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          case (r_cls)
            CLS_LOAD, CLS_STORE: r_state <= ST_MEM;
            CLS_BRANCH, CLS_ILL: r_state <= ST_FETCH;
            default:             r_state <= ST_WRITEBACK;
          endcase
        end
        ST_MEM: if (dmem_ready) r_state <= (r_cls == CLS_STORE) ? ST_FETCH : ST_WRITEBACK;
        ST_WRITEBACK: r_state <= ST_FETCH;
        ST_HALT:      r_state <= ST_HALT;
        default:      r_state <= ST_FETCH;
      endcase
    end
  end

  // ALU controls depend only on the class so they stay stable from EXECUTE through WRITEBACK
  always_comb begin
    w_alu_cmd   = ALU_R;
    w_alu_a_sel = ASEL_RS1;
    w_alu_src   = 1'b0;
    case (r_cls)
      CLS_I:               begin w_alu_cmd = ALU_I;     w_alu_src = 1'b1; end
      CLS_LOAD, CLS_STORE: begin w_alu_cmd = ALU_MEM;   w_alu_src = 1'b1; end
      CLS_BRANCH:          begin w_alu_cmd = ALU_BR; end
      CLS_JAL, CLS_AUIPC:  begin w_alu_cmd = ALU_ADDPC; w_alu_a_sel = ASEL_PC;   w_alu_src = 1'b1; end
      CLS_JALR:            begin w_alu_cmd = ALU_ADDPC; w_alu_src = 1'b1; end
      CLS_LUI:             begin w_alu_cmd = ALU_LUI;   w_alu_a_sel = ASEL_ZERO; w_alu_src = 1'b1; end
      default:             ;
    endcase
  end

  always_comb begin
    alu_cmd   = 4'b0000;
    alu_a_sel = 2'b00;
    alu_src   = 1'b0;
    pc_src    = PC_PLUS4;
    pc_load   = 1'b0;
    ir_load   = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    illegal   = 1'b0;
    state     = 3'd0;
    // Reset forces every output low immediately, including mid-MEM requests
    if (!reset) begin
      illegal = r_illegal;
      state   = r_state;
      case (r_state)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_load  = imem_ready;
        end
        ST_EXECUTE: begin
          alu_cmd   = w_alu_cmd;
          alu_a_sel = w_alu_a_sel;
          alu_src   = w_alu_src;
          if (r_cls == CLS_BRANCH) begin
            pc_load = 1'b1;
            pc_src  = w_taken ? PC_IMM : PC_PLUS4;
          end else if (r_cls == CLS_ILL) begin
            pc_load = 1'b1;
          end
        end
        ST_MEM: begin
          alu_cmd   = w_alu_cmd;
          alu_a_sel = w_alu_a_sel;
          alu_src   = w_alu_src;
          dmem_req  = 1'b1;
          dmem_we   = (r_cls == CLS_STORE);
          pc_load   = (r_cls == CLS_STORE) && dmem_ready;
        end
        ST_WRITEBACK: begin
          alu_cmd   = w_alu_cmd;
          alu_a_sel = w_alu_a_sel;
          alu_src   = w_alu_src;
          rf_we     = 1'b1;
          pc_load   = 1'b1;
          case (r_cls)
            CLS_LOAD:          wb_sel = WB_MEM;
            CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
            default:           wb_sel = WB_ALU;
          endcase
          case (r_cls)
            CLS_JAL:  pc_src = PC_IMM;
            CLS_JALR: pc_src = PC_ALU;
            default:  pc_src = PC_PLUS4;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_control_unit.sv
module tb_riscv_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] alu_flags;
  logic       imem_ready;
  logic       dmem_ready;
  logic [3:0] alu_cmd;
  logic [1:0] alu_a_sel;
  logic       alu_src;
  logic [1:0] pc_src;
  logic       pc_load;
  logic       ir_load;
  logic       imem_req;
  logic       dmem_req;
  logic       dmem_we;
  logic       rf_we;
  logic [1:0] wb_sel;
  logic       illegal;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  riscv_control_unit #(.XLEN(64), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_flags(alu_flags), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .alu_cmd(alu_cmd), .alu_a_sel(alu_a_sel), .alu_src(alu_src), .pc_src(pc_src),
    .pc_load(pc_load), .ir_load(ir_load), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal), .state(state)
  );

  logic [20:0] all_out;
  assign all_out = {alu_cmd, alu_a_sel, alu_src, pc_src, pc_load, ir_load, imem_req,
                    dmem_req, dmem_we, rf_we, wb_sel, illegal, state};

  // Every task starts and ends in the low clock phase with the FSM in FETCH.
  task automatic test_reset();
    reset = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0;
    alu_flags = 4'b1111; imem_ready = 1'b1; dmem_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    total++; if (all_out !== 21'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    reset = 1'b0; #1;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_release_state got=%0d exp=0", state); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_release_imem_req got=%b exp=1", imem_req); end
  endtask

  task automatic test_add();
    logic [11:0] seq = {3'd0, 3'd1, 3'd2, 3'd4};
    int rf_cnt = 0;
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000; imem_ready = 1'b1; alu_flags = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (state !== seq[11-3*i -: 3]) begin bad++; $display("FAIL add_state[%0d] got=%0d exp=%0d", i, state, seq[11-3*i -: 3]); end
      if (rf_we === 1'b1) rf_cnt++;
      if (i == 0) begin
        total++; if (ir_load !== 1'b1) begin bad++; $display("FAIL add_ir_load got=%b exp=1", ir_load); end
      end
      if (i == 2) begin
        total++; if ({alu_cmd, alu_a_sel, alu_src} !== 7'b0000_00_0) begin bad++; $display("FAIL add_exec_alu got=%b exp=0000000", {alu_cmd, alu_a_sel, alu_src}); end
      end
      if (i == 3) begin
        total++; if ({wb_sel, pc_src, pc_load} !== 5'b00_00_1) begin bad++; $display("FAIL add_wb got=%b exp=00001", {wb_sel, pc_src, pc_load}); end
      end
      @(negedge clk);
    end
    #1;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL add_end_state got=%0d exp=0", state); end
    total++; if (rf_cnt != 1) begin bad++; $display("FAIL add_rf_we_pulses got=%0d exp=1", rf_cnt); end
  endtask

  task automatic test_branches();
    logic [2:0] f3s   [8] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100, 3'b100, 3'b101, 3'b101};
    logic [3:0] flags [8] = '{4'b1001, 4'b1000, 4'b1001, 4'b1000, 4'b1010, 4'b1110, 4'b1010, 4'b1110};
    logic [1:0] exp_src [8] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
    opcode = 7'b1100011; imem_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      funct3 = f3s[k];
      for (int i = 0; i < 3; i++) begin
        alu_flags = (i == 2) ? flags[k] : 4'b1000;
        #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL br%0d_rf_we[%0d] got=%b exp=0", k, i, rf_we); end
        if (i == 2) begin
          total++; if ({state, alu_cmd, alu_src} !== {3'd2, 4'b0011, 1'b0}) begin bad++; $display("FAIL br%0d_exec got=%b exp=01000110", k, {state, alu_cmd, alu_src}); end
          total++; if ({pc_load, pc_src} !== {1'b1, exp_src[k]}) begin bad++; $display("FAIL br%0d_pc got=%b exp=%b", k, {pc_load, pc_src}, {1'b1, exp_src[k]}); end
        end
        @(negedge clk);
      end
      #1;
      total++; if (state !== 3'd0) begin bad++; $display("FAIL br%0d_latency state got=%0d exp=0", k, state); end
    end
    alu_flags = 4'b1000;
  endtask

  task automatic test_load_stall();
    logic [23:0] seq = {3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    int req_cnt = 0;
    opcode = 7'b0000011; funct3 = 3'b010; imem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dmem_ready = (i == 6);
      #1;
      total++; if (state !== seq[23-3*i -: 3]) begin bad++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, seq[23-3*i -: 3]); end
      if (dmem_req === 1'b1) req_cnt++;
      if (i >= 3 && i <= 6) begin
        total++; if ({dmem_req, dmem_we, alu_cmd} !== 6'b10_0010) begin bad++; $display("FAIL lw_mem[%0d] got=%b exp=100010", i, {dmem_req, dmem_we, alu_cmd}); end
      end
      if (i == 7) begin
        total++; if ({rf_we, pc_load, wb_sel, pc_src} !== 6'b11_01_00) begin bad++; $display("FAIL lw_wb got=%b exp=110100", {rf_we, pc_load, wb_sel, pc_src}); end
      end
      @(negedge clk);
    end
    #1;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL lw_end_state got=%0d exp=0", state); end
    total++; if (req_cnt != 4) begin bad++; $display("FAIL lw_dmem_req_cycles got=%0d exp=4", req_cnt); end
  endtask

  task automatic test_store();
    opcode = 7'b0100011; funct3 = 3'b010; imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i == 3) begin
        total++; if ({state, dmem_req, dmem_we, rf_we, pc_load, pc_src} !== {3'd3, 6'b11_0_1_00}) begin
          bad++; $display("FAIL sw_mem got=%b exp=011110100", {state, dmem_req, dmem_we, rf_we, pc_load, pc_src}); end
      end
      @(negedge clk);
    end
    #1;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL sw_latency state got=%0d exp=0", state); end
  endtask

  task automatic test_classes();
    // opcode, alu_cmd, alu_a_sel, alu_src, wb_sel, pc_src
    logic [6:0] opc [5] = '{7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [3:0] cmd [5] = '{4'b0001, 4'b0100, 4'b0100, 4'b0101, 4'b0100};
    logic [1:0] asl [5] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
    logic [1:0] wbs [5] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
    logic [1:0] pcs [5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
    imem_ready = 1'b1; funct3 = 3'b000;
    for (int k = 0; k < 5; k++) begin
      opcode = opc[k];
      for (int i = 0; i < 4; i++) begin
        #1;
        if (i == 2) begin
          total++; if ({alu_cmd, alu_a_sel, alu_src} !== {cmd[k], asl[k], 1'b1}) begin
            bad++; $display("FAIL cls%0d_exec got=%b exp=%b", k, {alu_cmd, alu_a_sel, alu_src}, {cmd[k], asl[k], 1'b1}); end
        end
        if (i == 3) begin
          total++; if ({state, rf_we, pc_load, wb_sel, pc_src, alu_cmd} !== {3'd4, 2'b11, wbs[k], pcs[k], cmd[k]}) begin
            bad++; $display("FAIL cls%0d_wb got=%b exp=%b", k, {state, rf_we, pc_load, wb_sel, pc_src, alu_cmd}, {3'd4, 2'b11, wbs[k], pcs[k], cmd[k]}); end
        end
        @(negedge clk);
      end
      #1;
      total++; if (state !== 3'd0) begin bad++; $display("FAIL cls%0d_latency state got=%0d exp=0", k, state); end
    end
  endtask

  task automatic test_illegal();
    opcode = 7'b1111111; funct3 = 3'b000; imem_ready = 1'b1; dmem_ready = 1'b1;
    @(negedge clk); #1;
    total++; if ({state, illegal} !== {3'd1, 1'b0}) begin bad++; $display("FAIL ill_decode got=%b exp=0010", {state, illegal}); end
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      #1;
      total++; if ({state, illegal, pc_load, rf_we, imem_req} !== {3'd5, 4'b1000}) begin
        bad++; $display("FAIL ill_halt[%0d] got=%b exp=1011000", i, {state, illegal, pc_load, rf_we, imem_req}); end
      @(negedge clk);
    end
    reset = 1'b1; @(negedge clk); reset = 1'b0; #1;
    total++; if ({state, illegal, imem_req} !== {3'd0, 2'b01}) begin bad++; $display("FAIL ill_reset got=%b exp=00001", {state, illegal, imem_req}); end
    // Unsigned branch compare cannot be resolved
    opcode = 7'b1100011; funct3 = 3'b011;
    @(negedge clk); @(negedge clk); #1;
    total++; if ({state, illegal} !== {3'd5, 1'b1}) begin bad++; $display("FAIL ill_bltu got=%b exp=1011", {state, illegal}); end
    reset = 1'b1; @(negedge clk); reset = 1'b0; #1;
  endtask

  task automatic test_store_reset();
    opcode = 7'b0100011; funct3 = 3'b011; imem_ready = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    total++; if ({state, dmem_req, dmem_we} !== {3'd3, 2'b11}) begin bad++; $display("FAIL swr_mem got=%b exp=01111", {state, dmem_req, dmem_we}); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if ({state, dmem_req, dmem_we} !== 5'b0) begin bad++; $display("FAIL swr_reset_edge got=%b exp=00000", {state, dmem_req, dmem_we}); end
    @(negedge clk);
    reset = 1'b0; #1;
    total++; if ({state, imem_req} !== {3'd0, 1'b1}) begin bad++; $display("FAIL swr_release got=%b exp=0001", {state, imem_req}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branches();
    test_load_stall();
    test_store();
    test_classes();
    test_illegal();
    test_store_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
